// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage states, reset PC default and instruction
// field positions used by both the fetch stage and the decode control unit.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // Opcode field of an instruction word, decoded by the control unit.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority selection: sequential PC+4, EX-stage branch target and
// ID-stage jump target, plus the flag telling the fetch stage to redirect.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] id_pc4,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              id_valid,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              redirect
);

    logic jump_go;

    // A branch resolved in EX is older than the jump in ID, so it wins.
    always_comb begin
        pc_plus4    = pc + ADDR_W'(4);
        jump_go     = jump && id_valid && !stall && !branch_taken;
        redirect    = branch_taken || jump_go;
        redirect_pc = {id_pc4[ADDR_W-1:28], jump_index, 2'b00};
        if (branch_taken) begin
            redirect_pc = {branch_target[ADDR_W-1:2], 2'b00};
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and fills the IF/ID register with a one-entry skid buffer.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [ADDR_W-1:0] pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc4
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   drop_addr_q, drop_addr_d;
    logic                id_valid_q, id_valid_d;
    logic [INSTR_W-1:0]  id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]   id_pc4_q, id_pc4_d;
    logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]   skid_pc4_q, skid_pc4_d;

    logic                handshake;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [ADDR_W-1:0]   pc_plus4;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc            (pc_q),
        .id_pc4        (id_pc4_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .id_valid      (id_valid_q),
        .stall         (stall),
        .pc_plus4      (pc_plus4),
        .redirect_pc   (redirect_pc),
        .redirect      (redirect)
    );

    // While DROP waits out a wrong-path response the pc register already holds
    // the new target, so the bus keeps presenting the old address.
    assign imem_req  = rst_n && (state_q != HOLD);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign handshake = imem_req && imem_ack;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc4_d     = id_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (redirect) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (!handshake) begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end
                HOLD:    state_d = FETCH;
                DROP:    state_d = handshake ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (handshake) begin
                        pc_d = pc_plus4;
                        if (!stall || !id_valid_q) begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rdata;
                            id_pc4_d   = pc_plus4;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = pc_plus4;
                            state_d      = HOLD;
                        end
                    end else if (!stall) begin
                        id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid_d = 1'b1;
                        id_instr_d = skid_instr_q;
                        id_pc4_d   = skid_pc4_q;
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    if (!stall) begin
                        id_valid_d = 1'b0;
                    end
                    if (handshake) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP;
            id_pc4_q     <= '0;
            skid_instr_q <= NOP;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc4_q     <= id_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign pc       = pc_q;
    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc4   = id_pc4_q;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage feeding the decode-stage control unit.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Holds the fetched word in the IF/ID register, whose opcode field [31:26] drives the control unit.
- Handles hazard stalls with a one-entry skid buffer, and redirects on taken branch (EX) or jump (ID) with wrong-path discard.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC / address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request, held until acked.
- imem_addr  out  ADDR_W  fetch address (= pc), stable while imem_req high.
- imem_ack  in  1  one-cycle completion pulse; may arrive in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- stall  in  1  decode cannot accept; IF/ID must hold.
- branch_taken  in  1  EX-stage branch & zero.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  ID-stage jump decode of id_instr.
- jump_index  in  26  id_instr[25:0].
- pc  out  ADDR_W  current fetch PC.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  IF/ID instruction.
- id_pc4  out  ADDR_W  IF/ID PC+4.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC, state=FETCH.
  - id_valid=0, id_instr=0, id_pc4=0, skid cleared.
  - imem_req=0 while rst_n low.
- States:
  - FETCH: imem_req=1.
  - HOLD: imem_req=0; fetched word parked in skid.
  - DROP: imem_req=1; outstanding response is wrong-path.
- A handshake completes on any edge with imem_req && imem_ack. imem_req is never withdrawn before ack.
- Redirect:
  - br = branch_taken.
  - jp = jump && id_valid && !stall && !branch_taken.
  - br has priority over jp.
  - Branch target = {branch_target[31:2], 2'b00}.
  - Jump target = {id_pc4[31:28], jump_index, 2'b00}.
- Any redirect:
  - pc <= target and id_valid <= 0, even when stall=1.
  - Skid is discarded.
  - Returned data in that cycle is discarded.
- FETCH, ack, no redirect:
  - If !stall or !id_valid: IF/ID <= {1, rdata, pc+4}, pc <= pc+4, stay FETCH.
  - Else: skid <= {rdata, pc+4}, pc <= pc+4, go HOLD.
- FETCH, no ack:
  - With redirect: go DROP.
  - Without redirect: stay FETCH; IF/ID holds when stall, else id_valid <= 0 (bubble).
- HOLD:
  - When !stall: IF/ID <= skid, go FETCH.
  - Redirect: go FETCH at target.
- DROP:
  - imem_addr stays at the old address (pc register is already the target; old address held internally).
  - On ack: discard, go FETCH.
  - A further redirect while in DROP updates the target and stays DROP.
- Latency and throughput:
  - Zero-wait memory (same-cycle ack) gives 1 instruction per cycle.
  - N-cycle ack gives 1 instruction per N+1 cycles.
  - Redirect to first target fetch issue is 1 cycle; +ack latency if in DROP.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset mid-request: the outstanding ack after reset release is treated as a fresh FETCH completion at RESET_PC. Memory is reset on the same rst_n.

Decomposition:
- Shared package cpu_pkg:
  - Fetch state enum {FETCH, HOLD, DROP}.
  - RESET_PC default.
  - INSTR_W=32.
  - NOP=32'h0.
  - Opcode field slice constants (OPC_MSB=31, OPC_LSB=26), which the control unit also uses.
- One natural sub-module: next_pc_sel. It is a combinational priority mux of pc+4, branch and jump targets, plus the redirect flag.

Test Plan:
- Reset, then zero-wait memory returning 0x8C010004, 0x20020005 -> id_instr 0x8C010004 with id_pc4=4, then 0x20020005 with id_pc4=8 on consecutive cycles; pc=8.
- Memory acks 3 cycles after req -> imem_req high with stable imem_addr for all 3 cycles; id_valid pulses 1 cycle per fetch with bubbles between.
- stall=1 for 4 cycles while an ack arrives -> word parked in skid, imem_req=0, id_instr unchanged. On stall release the skid word appears next cycle with no loss or duplication.
- id_instr=0x08000040 (j), jump=1, id_pc4=0x1000_0010 -> next imem_addr=0x1000_0100; id_valid=0 for one cycle.
- branch_taken=1, target 0x0000_0020, while a 2-cycle request to 0x14 is outstanding -> DROP, the 0x14 data is never presented (id_valid stays 0), then fetch issues at 0x20.
- pc=0xFFFF_FFFC, ack -> id_pc4=0, pc=0. Also assert rst_n=0 mid-request -> all outputs return to reset values on the next edge.
